// File: rtl/data_route_pkg.sv
// Shared types and helpers for the data_route fabric.
// Holds arbiter state encoding and sizing defaults.
package data_route_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int NUM_SRC_DEF = 4;
  localparam int SRC_W_DEF   = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches from last_gnt+1 upward, wrapping modulo N.
import data_route_pkg::*;

module rr_pick #(
  parameter int N = NUM_SRC_DEF,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_gnt,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  // first requester after last_gnt wins
  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_gnt) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin stream arbiter.
// One registered output stage, beats tagged with source id.
import data_route_pkg::*;

module stream_rr_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SRC_W   = SRC_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DWIDTH-1:0] s_in_tdata,
  input  logic [NUM_SRC-1:0]        s_in_tvalid,
  input  logic [NUM_SRC-1:0]        s_in_tlast,
  output logic [NUM_SRC-1:0]        s_in_tready,
  output logic [DWIDTH-1:0]         m_out_tdata,
  output logic                      m_out_tvalid,
  output logic                      m_out_tlast,
  output logic [SRC_W-1:0]          m_out_tid,
  input  logic                      m_out_tready,
  output logic                      busy
);

  arb_state_t        state, state_nx;
  logic [SRC_W-1:0]  last_gnt, last_nx;
  logic [SRC_W-1:0]  cur_src, cur_nx;
  logic              gnt_valid;
  logic [SRC_W-1:0]  gnt_idx;
  logic              stage_free;
  logic              sel_ok;
  logic [SRC_W-1:0]  sel_src;
  logic [DWIDTH-1:0] sel_data;
  logic              sel_last;
  logic              xfer;

  rr_pick #(
    .N(NUM_SRC),
    .W(SRC_W)
  ) u_pick (
    .req      (s_in_tvalid),
    .last_gnt (last_gnt),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign stage_free = ~m_out_tvalid | m_out_tready;
  assign busy       = (state == ARB_LOCK);

  // select owner: locked source, else fresh winner
  always_comb begin
    sel_ok      = (state == ARB_LOCK) | gnt_valid;
    sel_src     = (state == ARB_LOCK) ? cur_src : gnt_idx;
    sel_data    = s_in_tdata[int'(sel_src)*DWIDTH +: DWIDTH];
    sel_last    = s_in_tlast[sel_src];
    s_in_tready = '0;
    if (rst_n && sel_ok && stage_free)
      s_in_tready[sel_src] = 1'b1;
    xfer = rst_n & sel_ok & stage_free & s_in_tvalid[sel_src];
  end

  // next-state and priority pointer updates
  always_comb begin
    state_nx = state;
    last_nx  = last_gnt;
    cur_nx   = cur_src;
    unique case (state)
      ARB_IDLE: begin
        if (xfer) begin
          if (sel_last) begin
            last_nx = gnt_idx;
          end else begin
            cur_nx   = gnt_idx;
            state_nx = ARB_LOCK;
          end
        end
      end
      ARB_LOCK: begin
        if (xfer && sel_last) begin
          last_nx  = cur_src;
          state_nx = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  // arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      last_gnt <= SRC_W'(NUM_SRC - 1);
      cur_src  <= '0;
    end else begin
      state    <= state_nx;
      last_gnt <= last_nx;
      cur_src  <= cur_nx;
    end
  end

  // output register with full-throughput handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out_tvalid <= 1'b0;
      m_out_tdata  <= '0;
      m_out_tlast  <= 1'b0;
      m_out_tid    <= '0;
    end else if (xfer) begin
      m_out_tvalid <= 1'b1;
      m_out_tdata  <= sel_data;
      m_out_tlast  <= sel_last;
      m_out_tid    <= sel_src;
    end else if (m_out_tready) begin
      m_out_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter.
// Scoreboard queue holds expected output beats.
module tb_stream_rr_arbiter;

  typedef struct packed {
    logic [1:0]  tid;
    logic        last;
    logic [31:0] data;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] s_in_tdata;
  logic [3:0]   s_in_tvalid;
  logic [3:0]   s_in_tlast;
  logic [3:0]   s_in_tready;
  logic [31:0]  m_out_tdata;
  logic         m_out_tvalid;
  logic         m_out_tlast;
  logic [1:0]   m_out_tid;
  logic         m_out_tready;
  logic         busy;

  int    checks = 0;
  int    errors = 0;
  int    busy_cyc;
  int    pkt_cnt [4];
  bit    lock3 = 0;
  bit    out_rdy = 1;
  beat_t src_q [4][$];
  beat_t exp_q [$];

  stream_rr_arbiter #(
    .DWIDTH (32),
    .NUM_SRC(4),
    .SRC_W  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_in_tdata  (s_in_tdata),
    .s_in_tvalid (s_in_tvalid),
    .s_in_tlast  (s_in_tlast),
    .s_in_tready (s_in_tready),
    .m_out_tdata (m_out_tdata),
    .m_out_tvalid(m_out_tvalid),
    .m_out_tlast (m_out_tlast),
    .m_out_tid   (m_out_tid),
    .m_out_tready(m_out_tready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic [31:0] d,
                      input logic l);
    beat_t b;
    b.tid  = 2'(src);
    b.last = l;
    b.data = d;
    src_q[src].push_back(b);
    exp_q.push_back(b);
  endtask

  // one clock: drive at negedge, sample before posedge
  task automatic cycle();
    beat_t b;
    beat_t e;
    m_out_tready = out_rdy;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        s_in_tvalid[i]         = 1'b1;
        s_in_tdata[i*32 +: 32] = src_q[i][0].data;
        s_in_tlast[i]          = src_q[i][0].last;
      end else begin
        s_in_tvalid[i]         = 1'b0;
        s_in_tdata[i*32 +: 32] = '0;
        s_in_tlast[i]          = 1'b0;
      end
    end
    #1;
    chk("rdy_onehot", 64'($countones(s_in_tready) <= 1), 1);
    if (m_out_tvalid && !m_out_tready)
      chk("bp_rdy", s_in_tready, 0);
    if (lock3 && busy)
      chk("lock_rdy3", s_in_tready[3], 0);
    if (busy) busy_cyc++;
    if (m_out_tvalid && m_out_tready) begin
      b.tid  = m_out_tid;
      b.last = m_out_tlast;
      b.data = m_out_tdata;
      if (exp_q.size() == 0) begin
        chk("extra_beat", b, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", b, e);
      end
      if (m_out_tlast) pkt_cnt[m_out_tid]++;
    end
    for (int i = 0; i < 4; i++)
      if (s_in_tvalid[i] && s_in_tready[i])
        void'(src_q[i].pop_front());
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int beats;
    int len;
    logic [98:0] snap;
    rst_n        = 1'b0;
    m_out_tready = 1'b1;
    s_in_tdata   = '0;
    s_in_tlast   = '0;
    s_in_tvalid  = 4'hF;
    #1;
    chk("rst_tready", s_in_tready, 0);
    chk("rst_tvalid", m_out_tvalid, 0);
    chk("rst_tdata", m_out_tdata, 0);
    chk("rst_tlast", m_out_tlast, 0);
    chk("rst_tid", m_out_tid, 0);
    chk("rst_busy", busy, 0);
    s_in_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset priority: 0,2,0,2 one per cycle
    push(0, 32'h10, 1'b1);
    push(2, 32'h20, 1'b1);
    push(0, 32'h11, 1'b1);
    push(2, 32'h21, 1'b1);
    busy_cyc = 0;
    drain(50, n);
    chk("prio_cycles", n, 5);
    chk("prio_busy", busy_cyc, 0);

    // packet lock: src1 x4 while src3 waits
    push(0, 32'h0F, 1'b1);
    drain(50, n);
    for (int b = 1; b <= 4; b++)
      push(1, 32'h30 + b, 1'(b == 4));
    push(3, 32'h3F, 1'b1);
    lock3    = 1;
    busy_cyc = 0;
    drain(50, n);
    lock3 = 0;
    chk("lock_busy_cyc", busy_cyc, 3);
    chk("lock_cycles", n, 6);

    // backpressure mid-packet
    for (int b = 0; b < 8; b++)
      push(2, 32'hA0 + b, 1'(b == 7));
    for (int c = 0; c < 3; c++) cycle();
    out_rdy = 0;
    snap = {m_out_tdata, m_out_tlast, m_out_tid, 64'h0};
    chk("bp_valid", m_out_tvalid, 1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("bp_hold",
          {m_out_tdata, m_out_tlast, m_out_tid},
          snap[98:64]);
    end
    out_rdy = 1;
    drain(50, n);

    // wrap-around from last_gnt=3
    push(3, 32'h53, 1'b1);
    drain(50, n);
    push(0, 32'h50, 1'b1);
    push(3, 32'h54, 1'b1);
    drain(50, n);

    // async reset during beat 2 of 5
    for (int b = 1; b <= 5; b++)
      push(1, 32'h60 + b, 1'(b == 5));
    cycle();
    cycle();
    chk("mid_busy", busy, 1);
    chk("mid_valid", m_out_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_out_tvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tready", s_in_tready, 0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    s_in_tvalid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      push(i, 32'h70 + i, 1'b1);
    drain(50, n);

    // throughput: 100 packets round robin
    for (int i = 0; i < 4; i++) pkt_cnt[i] = 0;
    beats = 0;
    for (int k = 0; k < 100; k++) begin
      len = int'($urandom_range(1, 8));
      for (int b = 0; b < len; b++) begin
        push(k % 4,
             {8'(k % 4), 8'(k), 8'(b), 8'h5A},
             1'(b == len - 1));
        beats++;
      end
    end
    drain(2000, n);
    chk("util_cycles", n, beats + 1);
    for (int i = 0; i < 4; i++)
      chk("fair", pkt_cnt[i], 25);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
